unpack_prenorm: RTL and testbench

- Front-end counterpart to the rounder's normshift.
- Takes a packed IEEE operand, either double or single (single in low 32 bits).
- Classifies the operand and removes bias.
- Iteratively left-normalizes denormal significands, a few bits per cycle.
- Output is a significand with hidden bit at bit 52, plus a 13-bit two's-complement unbiased exponent in the same format normshift consumes.
- Sits between the operand registers and the FPU datapath, with valid/ready handshake on both sides.

---
 rtl/unpack_prenorm.sv | 130 +++++++++++++
 tb/tb_unpack_prenorm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/unpack_prenorm.sv
// Operand front end: unpacks a double or single IEEE operand, classifies it,
// removes the exponent bias and left-normalizes denormals STEP bits per cycle.
module unpack_prenorm #(
  parameter int unsigned STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] fin,
  input  logic        db,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sn,
  output logic [12:0] eu,
  output logic [52:0] fu,
  output logic        zero,
  output logic        inf,
  output logic        nan,
  output logic        snan
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nx;
  logic   accept;

  logic [10:0] ld_e;
  logic [51:0] ld_frac;
  logic [12:0] ld_bias;
  logic        ld_sn;
  logic        e_zero, e_max, frac_nz;
  logic        ld_shift;
  logic [12:0] ld_eu;
  logic [52:0] ld_fu;

  logic [STEP-1:0] win;
  logic [4:0]      z;
  logic [52:0]     sh_fu;
  logic [12:0]     sh_eu;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);

  // Single fraction is left-aligned to bit 51 so the quiet bit and the
  // significand layout are identical for both formats.
  always_comb begin
    ld_e    = '0;
    ld_frac = '0;
    ld_bias = 13'd1023;
    ld_sn   = fin[63];
    e_max   = 1'b0;
    if (db) begin
      ld_e    = fin[62:52];
      ld_frac = fin[51:0];
      ld_bias = 13'd1023;
      ld_sn   = fin[63];
      e_max   = (fin[62:52] == 11'h7FF);
    end else begin
      ld_e    = {3'b000, fin[30:23]};
      ld_frac = {fin[22:0], 29'b0};
      ld_bias = 13'd127;
      ld_sn   = fin[31];
      e_max   = (fin[30:23] == 8'hFF);
    end
    e_zero   = (ld_e == 11'd0);
    frac_nz  = (ld_frac != 52'd0);
    ld_shift = e_zero & frac_nz;
    ld_fu    = {~e_zero, ld_frac};
    ld_eu    = '0;
    if (ld_shift)
      ld_eu = 13'd1 - ld_bias;
    else if (!e_zero && !e_max)
      ld_eu = {2'b00, ld_e} - ld_bias;
  end

  // Leading-zero count of the top STEP bits; the highest set bit wins.
  always_comb begin
    win = fu[52 -: STEP];
    z   = 5'(STEP);
    for (int unsigned i = 0; i < STEP; i++) begin
      if (win[i]) z = 5'(STEP - 1 - i);
    end
    sh_fu = fu << z;
    sh_eu = eu - {8'b0, z};
  end

  always_comb begin
    state_nx = state;
    if (accept) begin
      state_nx = ld_shift ? SHIFT : DONE;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        SHIFT:   if (z != 5'(STEP)) state_nx = DONE;
        DONE:    if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sn    <= 1'b0;
      eu    <= '0;
      fu    <= '0;
      zero  <= 1'b0;
      inf   <= 1'b0;
      nan   <= 1'b0;
      snan  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sn   <= ld_sn;
        eu   <= ld_eu;
        fu   <= ld_fu;
        zero <= e_zero & ~frac_nz;
        inf  <= e_max & ~frac_nz;
        nan  <= e_max & frac_nz;
        snan <= e_max & frac_nz & ~ld_frac[51];
      end else if (state == SHIFT) begin
        fu <= sh_fu;
        eu <= sh_eu;
      end
    end
  end

endmodule

// File: tb/tb_unpack_prenorm.sv
// Directed vector bench for unpack_prenorm (STEP=8): class, exponent,
// significand, latency, backpressure, back-to-back accept and reset.
module tb_unpack_prenorm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] fin;
  logic        db;
  logic        out_valid;
  logic        out_ready;
  logic        sn;
  logic [12:0] eu;
  logic [52:0] fu;
  logic        zero, inf, nan, snan;

  int total = 0;
  int bad   = 0;

  unpack_prenorm #(.STEP(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fin(fin), .db(db), .out_valid(out_valid), .out_ready(out_ready),
    .sn(sn), .eu(eu), .fu(fu), .zero(zero), .inf(inf), .nan(nan), .snan(snan)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] fin;
    logic        db;
    int          lat;
    logic        sn;
    logic [12:0] eu;
    logic [52:0] fu;
    logic [3:0]  fl;   // {zero, inf, nan, snan}
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one operand, measure edges until out_valid, check outputs, then
  // stall one cycle with out_ready=0 before releasing back to IDLE.
  task automatic run_vec(input vec_t v);
    int cnt;
    @(negedge clk);
    in_valid  = 1'b1;
    fin       = v.fin;
    db        = v.db;
    out_ready = 1'b0;
    chk({v.name, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fin      = 64'hA5A5_5A5A_A5A5_5A5A;
    db       = ~v.db;
    @(negedge clk);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk({v.name, ".lat"}, 64'(cnt), 64'(v.lat));
    chk({v.name, ".sn"}, 64'(sn), 64'(v.sn));
    chk({v.name, ".eu"}, 64'(eu), 64'(v.eu));
    chk({v.name, ".fu"}, 64'(fu), 64'(v.fu));
    chk({v.name, ".flags"}, 64'({zero, inf, nan, snan}), 64'(v.fl));
    chk({v.name, ".in_ready_stall"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    chk({v.name, ".fu_hold"}, 64'(fu), 64'(v.fu));
    out_ready = 1'b1;
    @(negedge clk);
    chk({v.name, ".idle_valid"}, 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs.push_back('{"d_one",      64'h3FF0000000000000, 1'b1, 0, 1'b0, 13'h0000, 53'h10000000000000, 4'b0000});
    vecs.push_back('{"d_min_den",  64'h0000000000000001, 1'b1, 7, 1'b0, 13'h1BCE, 53'h10000000000000, 4'b0000});
    vecs.push_back('{"s_min_den",  64'hDEADBEEF00000001, 1'b0, 3, 1'b0, 13'h1F6B, 53'h10000000000000, 4'b0000});
    vecs.push_back('{"d_snan",     64'h7FF0000000000001, 1'b1, 0, 1'b0, 13'h0000, 53'h10000000000001, 4'b0011});
    vecs.push_back('{"d_qnan",     64'h7FF8000000000000, 1'b1, 0, 1'b0, 13'h0000, 53'h18000000000000, 4'b0010});
    vecs.push_back('{"s_ninf",     64'h00000000FF800000, 1'b0, 0, 1'b1, 13'h0000, 53'h10000000000000, 4'b0100});
    vecs.push_back('{"d_nzero",    64'h8000000000000000, 1'b1, 0, 1'b1, 13'h0000, 53'h00000000000000, 4'b1000});
    vecs.push_back('{"s_1p5",      64'h000000003FC00000, 1'b0, 0, 1'b0, 13'h0000, 53'h18000000000000, 4'b0000});
    vecs.push_back('{"d_den_lz1",  64'h0008000000000000, 1'b1, 1, 1'b0, 13'h1C01, 53'h10000000000000, 4'b0000});
    vecs.push_back('{"d_den_lz7",  64'h0000200000000000, 1'b1, 1, 1'b0, 13'h1BFB, 53'h10000000000000, 4'b0000});
    vecs.push_back('{"d_den_lz8",  64'h0000100000000000, 1'b1, 2, 1'b0, 13'h1BFA, 53'h10000000000000, 4'b0000});
    vecs.push_back('{"d_max",      64'h7FEFFFFFFFFFFFFF, 1'b1, 0, 1'b0, 13'h03FF, 53'h1FFFFFFFFFFFFF, 4'b0000});
    vecs.push_back('{"s_min_norm", 64'h0000000000800000, 1'b0, 0, 1'b0, 13'h1F82, 53'h10000000000000, 4'b0000});
    vecs.push_back('{"s_snan",     64'h000000007F800001, 1'b0, 0, 1'b0, 13'h0000, 53'h10000020000000, 4'b0011});

    rst = 1'b1; in_valid = 1'b0; fin = '0; db = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.fu", 64'(fu), 64'd0);
    chk("reset.eu", 64'(eu), 64'd0);
    chk("reset.flags", 64'({sn, zero, inf, nan, snan}), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure then same-edge accept of 2.0 with no bubble.
    @(negedge clk);
    in_valid = 1'b1; fin = 64'h3FF0000000000000; db = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp.out_valid", 64'(out_valid), 64'd1);
      chk("bp.in_ready", 64'(in_ready), 64'd0);
      chk("bp.fu", 64'(fu), 64'h10000000000000);
      chk("bp.eu", 64'(eu), 64'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; fin = 64'h4000000000000000;
    #1;
    chk("b2b.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("b2b.out_valid", 64'(out_valid), 64'd1);
    chk("b2b.eu", 64'(eu), 64'd1);
    chk("b2b.fu", 64'(fu), 64'h10000000000000);

    // From DONE, same-edge accept of a denormal drops out_valid.
    out_ready = 1'b1; in_valid = 1'b1; fin = 64'h0008000000000000; db = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_den.out_valid_shift", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("b2b_den.out_valid", 64'(out_valid), 64'd1);
    chk("b2b_den.eu", 64'(eu), 64'h1C01);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the third SHIFT cycle of the minimum double denormal.
    in_valid = 1'b1; fin = 64'h0000000000000001; db = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid.in_shift", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid.fu", 64'(fu), 64'd0);
    chk("rst_mid.eu", 64'(eu), 64'd0);
    chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
